// File: rtl/lmc_ram_bank.sv
// LMC mailbox store: parametrised RAM with a combinational read port.
// A clear sequencer zeroes every word after reset or on request.
// Writes that arrive while the sequencer owns the array are dropped and flagged.
module lmc_ram_bank #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned ADDR_W     = 2,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear_req,
    output logic [DATA_W-1:0] RAM_out,
    output logic              busy,
    output logic              wr_drop
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                busy_q, busy_d;
    logic                wr_drop_q, wr_drop_d;

    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_wadr_c;
    logic [DATA_W-1:0]   mem_wdata_c;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Next-state, clear pointer and single shared array write port.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        wr_drop_d   = 1'b0;
        mem_we_c    = 1'b0;
        mem_wadr_c  = adr;
        mem_wdata_c = data_in;
        unique case (state_q)
            ST_IDLE: begin
                // A write on the same edge as a clear request still lands.
                mem_we_c = we;
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            ST_CLEAR: begin
                // clear_req is ignored here: no restart of the pointer.
                mem_we_c    = 1'b1;
                mem_wadr_c  = clr_ptr_q;
                mem_wdata_c = '0;
                clr_ptr_d   = clr_ptr_q + ADDR_W'(1);
                wr_drop_d   = we;
                if (clr_ptr_q == LAST_ADR) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Control registers; reset restarts the clear from location 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
            clr_ptr_q <= '0;
            busy_q    <= INIT_CLEAR;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_wadr_c] <= mem_wdata_c;
        end
    end

    assign RAM_out = busy_q ? '0 : mem_q[adr];
    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule
